// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the counter arbiter and its helpers.
//   - bool_t / uint8_t style typedefs
//   - opcode encodings carried on each requester's op slice
//   - arbiter FSM state encoding
package counter_arbiter_pkg;

  typedef logic       bool_t;
  typedef logic [7:0] uint8_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STEP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req    : request vector
//   last   : id of the previous winner; search starts at last+1 (mod NREQ)
//   onehot : one-hot winner (all zero when no request)
//   id     : binary id of the winner (zero when no request)
module counter_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  id
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  always_comb begin
    int      idx;
    logic    found;
    logic [SW-1:0] sel;
    onehot = '0;
    id     = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    // k = NREQ wraps back to last itself, so it has the lowest priority.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      sel = SW'(idx);
      if (!found && req[sel]) begin
        found       = 1'b1;
        onehot[sel] = 1'b1;
        id          = IDW'(sel);
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shares one WIDTH-bit up-counter among NREQ requesters.
//   clk, rst      : clock, synchronous active-high reset
//   req[NREQ]     : request levels, held until the matching gnt pulse
//   op[2*NREQ]    : per-requester opcode (NOP/CLEAR/LOAD/STEP)
//   arg[W*NREQ]   : per-requester LOAD value or STEP count
//   gnt[NREQ]     : one-hot single-cycle grant pulse
//   busy          : high while executing or responding
//   done, done_id : single-cycle completion pulse and requester id
//   count, msb    : counter value and its top bit
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] arg,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      count,
  output logic                  msb
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  // Holds the LOAD value, or the remaining STEP count (decremented per step).
  logic [WIDTH-1:0] arg_q,   arg_d;
  logic [1:0]       op_q,    op_d;
  logic [IDW-1:0]   id_q,    id_d;
  logic [IDW-1:0]   last_q,  last_d;
  logic [NREQ-1:0]  gnt_q,   gnt_d;

  logic [NREQ-1:0]  pick_oh;
  logic [IDW-1:0]   pick_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_arg;

  counter_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req    (req),
    .last   (last_q),
    .onehot (pick_oh),
    .id     (pick_id)
  );

  // Operand mux steered by the one-hot winner.
  always_comb begin
    sel_op  = OP_NOP;
    sel_arg = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_op  = op[2*i +: 2];
        sel_arg = arg[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    arg_d   = arg_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = pick_oh;
          last_d  = pick_id;
          id_d    = pick_id;
          op_d    = sel_op;
          arg_d   = sel_arg;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_NOP:   state_d = ST_RESP;
          OP_CLEAR: begin count_d = '0;    state_d = ST_RESP; end
          OP_LOAD:  begin count_d = arg_q; state_d = ST_RESP; end
          default: begin
            if (arg_q == '0) begin
              state_d = ST_RESP;
            end else begin
              count_d = count_q + 1'b1;
              arg_d   = arg_q - 1'b1;
              if (arg_q == WIDTH'(1)) state_d = ST_RESP;
            end
          end
        endcase
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      arg_q   <= '0;
      op_q    <= OP_NOP;
      id_q    <= '0;
      last_q  <= IDW'(NREQ-1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      arg_q   <= arg_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_RESP);
  assign done_id = done ? id_q : '0;
  assign count   = count_q;
  assign msb     = count_q[WIDTH-1];

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int NREQ = 4, WIDTH = 8, IDW = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [2*NREQ-1:0]     op  = '0;
  logic [WIDTH*NREQ-1:0] arg = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy, done, msb;
  logic [IDW-1:0]        done_id;
  logic [WIDTH-1:0]      count;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .arg(arg),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .count(count), .msb(msb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct { int id; logic [WIDTH-1:0] cnt; int cyc; } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (gnt != '0) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done_id %0d with empty scoreboard (cycle %0d)", done_id, cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_id",    32'(done_id), 32'(e.id));
        chk("done_count", 32'(count),   32'(e.cnt));
        chk("done_cycle", 32'(cyc),     32'(e.cyc));
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] o, input logic [WIDTH-1:0] a);
    op[2*i +: 2]          = o;
    arg[WIDTH*i +: WIDTH] = a;
    req[i]                = 1'b1;
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] mask, output int gc);
    gc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if ((gnt & mask) != '0) begin gc = cyc; return; end
    end
    n_cmp++; n_bad++;
    $display("FAIL gnt_timeout: got no grant for mask %0h, want one", mask);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy && gnt == '0) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL idle_timeout: got busy still 1, want 0");
  endtask

  task automatic issue(input int i, input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input int lat, input logic [WIDTH-1:0] expcnt, output int gc);
    set_req(i, o, a);
    wait_gnt(NREQ'(1) << i, gc);
    req[i] = 1'b0;
    if (gc >= 0) sbq.push_back('{id: i, cnt: expcnt, cyc: gc + lat});
  endtask

  initial begin
    int gc, gc2, prev, e;
    // Reset and idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_msb",   32'(msb),   0);
    chk("rst_gnt",   32'(gnt),   0);
    chk("rst_done",  32'(done),  0);
    chk("rst_busy",  32'(busy),  0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_count", 32'(count), 0);
    chk("idle_gnt",   32'(gnt),   0);

    // LOAD 0xFE, then STEP 3 wrapping through 0
    issue(0, OP_LOAD, 8'hFE, 1, 8'hFE, gc);
    @(negedge clk);
    chk("load_count", 32'(count), 32'hFE);
    chk("load_msb",   32'(msb),   1);
    wait_idle();
    issue(0, OP_STEP, 8'd3, 3, 8'h01, gc);
    @(negedge clk); chk("step_1", 32'(count), 32'hFF);
    @(negedge clk); chk("step_2", 32'(count), 32'h00);
    @(negedge clk); chk("step_3", 32'(count), 32'h01);
    wait_idle();

    // Round robin from a fresh reset: 0,1,2,3,0, three cycles apart
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op = '0;
    req = 4'hF;
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      e = k % NREQ;
      wait_gnt(4'hF, gc);
      chk("rr_gnt", 32'(gnt), 32'(1) << e);
      if (prev >= 0) chk("rr_spacing", 32'(gc - prev), 3);
      prev = gc;
      if (gc >= 0) sbq.push_back('{id: e, cnt: 8'h00, cyc: gc + 1});
      if (k == 4) req = '0;
      @(negedge clk);
      chk("rr_gnt_width", 32'(gnt), 0);
    end
    wait_idle();

    // Inputs ignored while busy
    issue(1, OP_STEP, 8'd10, 10, 8'd10, gc);
    @(negedge clk);
    set_req(2, OP_CLEAR, 8'h00);
    arg[WIDTH*1 +: WIDTH] = 8'd1;
    wait_gnt(4'b0100, gc2);
    chk("busy_gnt2",        32'(gnt),   32'b0100);
    chk("busy_gnt2_cycle",  32'(gc2 - gc), 12);
    chk("busy_count_10",    32'(count), 10);
    if (gc2 >= 0) sbq.push_back('{id: 2, cnt: 8'h00, cyc: gc2 + 1});
    req[2] = 1'b0;
    wait_idle();

    // Reset mid-burst
    set_req(2, OP_STEP, 8'd200);
    wait_gnt(4'b0100, gc);
    req[2] = 1'b0;
    repeat (50) @(negedge clk);
    chk("burst_count_50", 32'(count), 50);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_busy",  32'(busy),  0);
    chk("midrst_done",  32'(done),  0);
    rst = 1'b0;
    set_req(0, OP_NOP, 8'h00);
    set_req(3, OP_NOP, 8'h00);
    wait_gnt(4'b1001, gc);
    chk("midrst_pri", 32'(gnt), 32'b0001);
    if (gc >= 0) sbq.push_back('{id: 0, cnt: 8'h00, cyc: gc + 1});
    req = '0;
    wait_idle();

    // STEP 0: no increment, two busy cycles
    issue(1, OP_STEP, 8'd0, 1, 8'h00, gc);
    chk("step0_busy_exec", 32'(busy), 1);
    @(negedge clk);
    chk("step0_busy_resp", 32'(busy),  1);
    chk("step0_count",     32'(count), 0);
    @(negedge clk);
    chk("step0_idle", 32'(busy), 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one WIDTH-bit up-counter datapath (clear / increment / msb tap) among NREQ requesters.
- Round-robin grant; sequences multi-cycle step bursts; reports completion per requester.
- Sits between client blocks and the shared counter.
- Counter register lives inside this block; msb is exported as the shared "d" tap.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, counter width in bits
IDW, 2, requester id width, must be >= clog2(NREQ)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request level; held until its gnt bit pulses
op  input  2*NREQ  per-requester opcode, slice i = op[2i+1:2i]; 0=NOP, 1=CLEAR, 2=LOAD, 3=STEP
arg  input  WIDTH*NREQ  per-requester operand, slice i = arg[WIDTH*i +: WIDTH]; LOAD value or STEP count
gnt  output  NREQ  one-hot, single-cycle grant pulse
busy  output  1  high in EXEC and RESP states
done  output  1  single-cycle completion pulse
done_id  output  IDW  id of the completing requester; valid only when done=1
count  output  WIDTH  current counter value
msb  output  1  count[WIDTH-1], combinational from the count register

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; count=0; gnt=0; done=0; done_id=0; last pointer=NREQ-1, so requester 0 has top priority after reset. Reset aborts any operation mid-flight; no done is produced for it.
- States: IDLE, EXEC, RESP. Encoding is in the shared package.
- IDLE:
  - Sampled at edge E: if any req bit is set, pick the first set bit searching upward from last+1, modulo NREQ.
  - At E: gnt<=onehot(winner); last<=winner; latch op, arg and id; state<=EXEC.
  - No req: stay in IDLE, gnt=0.
- EXEC (gnt is high during the first EXEC cycle only):
  - NOP: count unchanged; state<=RESP.
  - CLEAR: count<=0; state<=RESP.
  - LOAD: count<=latched arg; state<=RESP.
  - STEP: count<=count+1 each edge, wrapping 2^WIDTH-1 -> 0; remaining<=remaining-1.
    - Go to RESP at the edge where remaining==1.
    - arg=0: no increment; straight to RESP.
- RESP: done=1 and done_id=latched id for exactly one cycle; state<=IDLE.
- Latency, with req sampled at edge E:
  - gnt visible in cycle E..E+1.
  - NOP/CLEAR/LOAD: count updated after E+1; done high E+1..E+2.
  - STEP n (n>=1): count final after E+n; done high E+n..E+n+1.
  - Next grant is possible at edge E+n+2 (E+3 for single-cycle ops).
- req and op/arg are ignored outside IDLE. Changing them while busy has no effect.
- A requester whose req is still high after its done is re-arbitrated normally; round-robin prevents starvation.
- Simultaneous requests: exactly one grant per arbitration; the others wait.
- Arithmetic: modulo 2^WIDTH, unsigned; no saturation, no carry output.
- count changes only in EXEC, or on reset.

Decomposition:
- Shared package holds:
  - bool/uint8_t-style typedefs;
  - opcode constants OP_NOP/OP_CLEAR/OP_LOAD/OP_STEP;
  - state enum values.
- One sub-module, rr_pick: combinational round-robin priority picker with inputs req, last and outputs onehot, id. It is reusable by other shared-resource arbiters.
- Counter datapath stays inline as reset/tock-style task logic.

Test Plan:
- Reset then idle: rst for 2 cycles -> count=0, msb=0, gnt=0, done=0, busy=0. Hold 5 cycles with no req -> count still 0.
- LOAD then STEP with wrap: req0 LOAD arg=0xFE, then req0 STEP arg=3.
  - After LOAD: count=0xFE, msb=1.
  - STEP progresses 0xFF, 0x00, 0x01.
  - done pulses once per op with done_id=0.
  - STEP done occurs 3 cycles after its gnt edge.
- Round-robin fairness: req0..req3 all held high with NOP ops.
  - Grant order 0,1,2,3,0.
  - Each grant is exactly 3 cycles apart.
  - Each gnt is one-hot and one cycle wide.
- Ignore while busy: req1 STEP arg=10. During EXEC, req2 asserts CLEAR and req1 changes arg to 1.
  - count=10 from 0.
  - Then req2 is granted; count=0.
- Reset mid-burst: STEP arg=200 and assert rst at step 50.
  - Next cycle: count=0, state IDLE, busy=0, no done.
  - Then requester 0 wins over requester 3 when both request.
- STEP arg=0: count unchanged, done pulses 1 cycle after the gnt cycle, busy for 2 cycles.
